// File: rtl/priority_dec_2_4_v__hold_pkg.sv
// priority_dec_2_4_v__hold_pkg: shared code width default and FSM state encodings
package priority_dec_2_4_v__hold_pkg;
  localparam int CODE_W_DEF = 2;
  typedef enum logic {ST_IDLE = 1'b0, ST_HOLD = 1'b1} state_t;
endpackage

// File: rtl/priority_dec_2_4_v__hold_onehot.sv
// priority_dec_2_4_v__hold_onehot: combinational code to one-hot decoder
module priority_dec_2_4_v__hold_onehot
  import priority_dec_2_4_v__hold_pkg::*;
#(
  parameter int CODE_W = CODE_W_DEF
) (
  input  logic [CODE_W-1:0]      i_code,
  output logic [(1<<CODE_W)-1:0] o_onehot
);
  assign o_onehot = {{((1 << CODE_W) - 1){1'b0}}, 1'b1} << i_code;
endmodule

// File: rtl/priority_dec_2_4_v__hold.sv
// priority_dec_2_4_v__hold: registered one-hot decoder holding each code HOLD_CYCLES clocks (PRIORITY_DEC_BACK2BACK_EN allows reload on the last hold cycle)
module priority_dec_2_4_v__hold
  import priority_dec_2_4_v__hold_pkg::*;
#(
  parameter int CODE_W      = CODE_W_DEF,
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [CODE_W-1:0]      i_code,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic [(1<<CODE_W)-1:0] o_onehot,
  output logic                   o_valid,
  output logic [CNT_W-1:0]       o_busy_cnt
);
  localparam int OH_W = 1 << CODE_W;
  state_t            state_q, state_d;
  logic [OH_W-1:0]   onehot_q, onehot_d, dec;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              hold, last, xfer;
  priority_dec_2_4_v__hold_onehot #(.CODE_W(CODE_W)) u_dec (
    .i_code   (i_code),
    .o_onehot (dec)
  );
  assign hold = state_q == ST_HOLD;
  assign last = hold && cnt_q == CNT_W'(1);
`ifdef PRIORITY_DEC_BACK2BACK_EN
  assign o_ready = !hold || last;
`else
  assign o_ready = !hold;
`endif
  assign xfer       = i_valid && o_ready;
  assign o_onehot   = onehot_q;
  assign o_valid    = hold;
  assign o_busy_cnt = cnt_q;
  // next state: a transfer loads code and counter, the last hold cycle returns to idle
  always_comb begin
    state_d  = xfer ? ST_HOLD : last ? ST_IDLE : state_q;
    onehot_d = xfer ? dec : last ? '0 : onehot_q;
    cnt_d    = xfer ? CNT_W'(HOLD_CYCLES) : hold ? cnt_q - CNT_W'(1) : cnt_q;
  end
  // state, output and counter registers; reset overrides any simultaneous transfer
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      onehot_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      onehot_q <= onehot_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: tb/tb_priority_dec_2_4_v__hold.sv
// tb_priority_dec_2_4_v__hold: scoreboard bench for the hold decoder
module tb_priority_dec_2_4_v__hold;
`ifdef PRIORITY_DEC_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif
  typedef struct {
    logic [3:0] oh;
    logic [7:0] cnt;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_valid = 1'b0;
  logic [1:0] i_code = 2'b00;
  logic       o_ready, o_valid;
  logic [3:0] o_onehot;
  logic [7:0] o_busy_cnt;
  exp_t       q[$];
  exp_t       e_m;
  int         checks = 0, errors = 0, cyc = 0;
  int         a1, a2;
  logic [3:0] codes_oh [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [3:0] enc_in   [3] = '{4'b1111, 4'b0100, 4'b0000};
  logic [3:0] enc_oh   [3] = '{4'b1000, 4'b0100, 4'b0000};

  priority_dec_2_4_v__hold dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_code     (i_code),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .o_onehot   (o_onehot),
    .o_valid    (o_valid),
    .o_busy_cnt (o_busy_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // monitor: pops one expected entry per live output cycle, checks idle outputs otherwise
  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got onehot %b with empty scoreboard at cycle %0d", o_onehot, cyc);
      end else begin
        e_m = q.pop_front();
        chk("onehot", 32'(o_onehot), 32'(e_m.oh));
        chk("busy_cnt", 32'(o_busy_cnt), 32'(e_m.cnt));
        chk("ready_hold", 32'(o_ready), 32'(B2B && e_m.cnt == 8'd1));
      end
    end else begin
      chk("idle_valid", 32'(o_valid), 32'd0);
      chk("idle_onehot", 32'(o_onehot), 32'd0);
      chk("idle_cnt", 32'(o_busy_cnt), 32'd0);
      chk("idle_ready", 32'(o_ready), 32'd1);
    end
  end

  task automatic send(input logic [1:0] c, input logic [3:0] oh, output int acc);
    logic r;
    exp_t e;
    acc = -1;
    #1;
    i_valid = 1'b1;
    i_code  = c;
    for (int k = 0; k < 30 && acc < 0; k++) begin
      @(negedge clk);
      r = o_ready;
      @(posedge clk);
      if (r) begin
        acc = cyc;
        for (int j = 0; j < 4; j++) begin
          e.oh  = oh;
          e.cnt = 8'(4 - j);
          q.push_back(e);
        end
      end
    end
    if (acc < 0) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: code %0d never accepted", c);
    end
  endtask

  task automatic drain();
    #1;
    i_valid = 1'b0;
    i_code  = 2'b11;
    for (int k = 0; k < 40 && q.size() > 0; k++) @(posedge clk);
    chk("drain_empty", 32'(q.size()), 32'd0);
    @(posedge clk);
  endtask

  function automatic void enc(input logic [3:0] d, output logic [1:0] c, output logic v);
    v = |d;
    c = d[3] ? 2'd3 : d[2] ? 2'd2 : d[1] ? 2'd1 : 2'd0;
  endfunction

  initial begin
    logic [1:0] ec;
    logic       ev;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", 32'(o_ready), 32'd1);
    chk("reset_onehot", 32'(o_onehot), 32'd0);
    @(posedge clk);
    for (int c = 0; c < 4; c++) begin
      send(2'(c), codes_oh[c], a1);
      drain();
    end
    #1;
    i_valid = 1'b0;
    i_code  = 2'b11;
    repeat (10) @(posedge clk);
    chk("invalid_q", 32'(q.size()), 32'd0);
    send(2'd1, 4'b0010, a1);
    send(2'd3, 4'b1000, a2);
    chk("b2b_gap", 32'(a2 - a1), B2B ? 32'd4 : 32'd5);
    drain();
    send(2'd2, 4'b0100, a1);
    #1 i_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst     = 1'b1;
    i_valid = 1'b1;
    i_code  = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    rst     = 1'b0;
    i_valid = 1'b0;
    q.delete();
    @(negedge clk);
    chk("rst_mid_valid", 32'(o_valid), 32'd0);
    chk("rst_mid_onehot", 32'(o_onehot), 32'd0);
    chk("rst_mid_cnt", 32'(o_busy_cnt), 32'd0);
    chk("rst_mid_ready", 32'(o_ready), 32'd1);
    @(posedge clk);
    for (int t = 0; t < 3; t++) begin
      enc(enc_in[t], ec, ev);
      if (ev) send(ec, enc_oh[t], a1);
      else begin
        #1;
        i_valid = 1'b0;
        i_code  = ec;
        repeat (6) @(posedge clk);
      end
      drain();
    end
    chk("final_q_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
